pid_pwm_stage: RTL and testbench



---
 rtl/pid_pwm_stage.sv | 134 +++++++++++++
 tb/tb_pid_pwm_stage.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_stage.sv
// PWM output stage for pid_controller: shadowed duty handshake,
// period-boundary updates. Optional watchdog: define PID_PWM_WDOG_EN.
module pid_pwm_stage #(
    parameter int PRESCALE     = 1,
    parameter int WDOG_PERIODS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty_active,
    output logic       update_pending,
    output logic       wdog_fault
);

    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);
    localparam logic [7:0] CNT_LAST = 8'd254;

    if (PRESCALE < 1 || PRESCALE > 256 || WDOG_PERIODS < 1) begin : g_bad_cfg
        $error("pid_pwm_stage: PRESCALE must be 1..256, WDOG_PERIODS >= 1");
    end

    logic [7:0] pre;
    logic [7:0] cnt;
    logic [7:0] shadow;
    logic       tick;
    logic       wrap;
    logic       accept;
    logic       wdog_hold;

    assign tick       = enable && (pre == PRE_LAST);
    assign wrap       = tick && (cnt == CNT_LAST);
    assign duty_ready = !update_pending;
    assign accept     = duty_valid && duty_ready;

`ifdef PID_PWM_WDOG_EN
    localparam int WW = $clog2(WDOG_PERIODS + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_PERIODS - 1);

    logic [WW-1:0] wdog_cnt;
    logic          fault_q;
    logic          wdog_trip;

    // trip on the wrap that completes WDOG_PERIODS idle periods
    assign wdog_trip = wrap && !fault_q && !accept
                     && (wdog_cnt == WDOG_LAST);
    assign wdog_hold = fault_q || wdog_trip;
    assign wdog_fault = fault_q;

    // count idle periods since the last accepted duty; sticky fault
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (accept) begin
                wdog_cnt <= '0;
            end else if (wrap && !fault_q) begin
                wdog_cnt <= wdog_cnt + WW'(1);
            end
            if (wdog_trip) begin
                fault_q <= 1'b1;
            end
        end
    end
`else
    assign wdog_hold  = 1'b0;
    assign wdog_fault = 1'b0;
`endif

    // prescaler: free-running while enabled, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 8'd1;
        end
    end

    // period counter 0..254, one step per tick
    always_ff @(posedge clk) begin
        if (rst || !enable || wrap) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 8'd1;
        end
    end

    // shadow register and boundary-aligned duty update
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow         <= '0;
            duty_active    <= '0;
            update_pending <= 1'b0;
        end else if (wdog_hold) begin
            duty_active    <= '0;
            update_pending <= 1'b0;
            if (accept) begin
                shadow <= duty_in;
            end
        end else if (!enable) begin
            update_pending <= 1'b0;
            if (accept) begin
                duty_active <= duty_in;
            end else if (update_pending) begin
                duty_active <= shadow;
            end
        end else if (wrap && update_pending) begin
            duty_active    <= shadow;
            update_pending <= 1'b0;
        end else if (wrap && accept) begin
            duty_active <= duty_in;
        end else if (accept) begin
            shadow         <= duty_in;
            update_pending <= 1'b1;
        end
    end

    // registered compare output and period marker
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= enable && !wdog_hold && (cnt < duty_active);
            period_start <= tick && (cnt == 8'd0);
        end
    end

endmodule

// File: tb/tb_pid_pwm_stage.sv
// Directed testbench for pid_pwm_stage (PRESCALE=1 main instance,
// PRESCALE=2 / WDOG_PERIODS=4 second instance).
module tb_pid_pwm_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;
    logic       update_pending;
    logic       wdog_fault;

    logic       en2;
    logic [7:0] din2;
    logic       dv2;
    logic       ready2;
    logic       pwm2;
    logic       ps2;
    logic [7:0] act2;
    logic       pend2;
    logic       fault2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pid_pwm_stage #(.PRESCALE(1), .WDOG_PERIODS(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .duty_in(duty_in), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .pwm_out(pwm_out),
        .period_start(period_start), .duty_active(duty_active),
        .update_pending(update_pending), .wdog_fault(wdog_fault)
    );

    pid_pwm_stage #(.PRESCALE(2), .WDOG_PERIODS(4)) u_p2 (
        .clk(clk), .rst(rst), .enable(en2),
        .duty_in(din2), .duty_valid(dv2),
        .duty_ready(ready2), .pwm_out(pwm2),
        .period_start(ps2), .duty_active(act2),
        .update_pending(pend2), .wdog_fault(fault2)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // sample n cycles from the current negedge on the main instance
    task automatic measure(input int n, output int hi, output int np,
                           output int last_ps);
        hi = 0; np = 0; last_ps = -1;
        for (int i = 0; i < n; i++) begin
            if (pwm_out) hi++;
            if (period_start) begin np++; last_ps = i; end
            step();
        end
    endtask

    task automatic wait_ps(input string name);
        bit found = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (period_start) begin found = 1; break; end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: period_start got none required pulse", name);
        end
    endtask

    task automatic send(input logic [7:0] d);
        duty_in = d; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; duty_valid = 1'b0; duty_in = 8'd0;
        en2 = 1'b0; dv2 = 1'b0; din2 = 8'd0;
        step(); step();
        checks++;
        if ({pwm_out, period_start, duty_active, update_pending,
             duty_ready, wdog_fault} !== 13'b0_0_00000000_0_1_0) begin
            failures++;
            $display("FAIL reset_state: got %b%b %h %b%b%b required 00 00 010",
                     pwm_out, period_start, duty_active, update_pending,
                     duty_ready, wdog_fault);
        end
        checks++;
        if ({pwm2, ps2, act2, pend2, ready2, fault2}
            !== 13'b0_0_00000000_0_1_0) begin
            failures++;
            $display("FAIL reset_state_p2: got %b%b %h %b%b%b required 00 00 010",
                     pwm2, ps2, act2, pend2, ready2, fault2);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_duty();
        int hi, np, lp;
        send(8'd64);
        checks++;
        if (duty_active !== 8'd64 || update_pending !== 1'b0) begin
            failures++;
            $display("FAIL disabled_load: active=%0d pend=%b required 64 0",
                     duty_active, update_pending);
        end
        enable = 1'b1;
        step();
        checks++;
        if (period_start !== 1'b1) begin
            failures++;
            $display("FAIL enable_ps: got %b required 1", period_start);
        end
        measure(510, hi, np, lp);
        checks++;
        if (hi !== 128) begin
            failures++;
            $display("FAIL duty64_high: got %0d required 128", hi);
        end
        checks++;
        if (np !== 2 || lp !== 255) begin
            failures++;
            $display("FAIL duty64_period: pulses=%0d last=%0d required 2 255",
                     np, lp);
        end
    endtask

    task automatic test_midperiod();
        int hi, np, lp, bad;
        send(8'd200);
        checks++;
        if (update_pending !== 1'b1) begin
            failures++;
            $display("FAIL pend200: got %b required 1", update_pending);
        end
        wait_ps("ps200");
        checks++;
        if (duty_active !== 8'd200 || update_pending !== 1'b0) begin
            failures++;
            $display("FAIL apply200: active=%0d pend=%b required 200 0",
                     duty_active, update_pending);
        end
        repeat (99) step();
        duty_in = 8'd50; duty_valid = 1'b1;
        step();
        checks++;
        if (update_pending !== 1'b1 || duty_ready !== 1'b0
            || duty_active !== 8'd200) begin
            failures++;
            $display("FAIL mid_accept: pend=%b ready=%b active=%0d required 1 0 200",
                     update_pending, duty_ready, duty_active);
        end
        duty_in = 8'd77;
        bad = 0;
        for (int j = 1; j <= 153; j++) begin
            step();
            if (update_pending !== 1'b1 || duty_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_hold: got %0d bad cycles required 0", bad);
        end
        step();
        duty_valid = 1'b0;
        checks++;
        if (duty_active !== 8'd50 || update_pending !== 1'b0
            || duty_ready !== 1'b1) begin
            failures++;
            $display("FAIL wrap_apply50: active=%0d pend=%b ready=%b required 50 0 1",
                     duty_active, update_pending, duty_ready);
        end
        step();
        checks++;
        if (period_start !== 1'b1) begin
            failures++;
            $display("FAIL ps50: got %b required 1", period_start);
        end
        measure(255, hi, np, lp);
        checks++;
        if (hi !== 50) begin
            failures++;
            $display("FAIL duty50_high: got %0d required 50", hi);
        end
    endtask

    task automatic test_extremes();
        int hi, np, lp;
        send(8'd0);
        wait_ps("ps0");
        measure(255, hi, np, lp);
        checks++;
        if (hi !== 0) begin
            failures++;
            $display("FAIL duty0_high: got %0d required 0", hi);
        end
        send(8'd255);
        wait_ps("ps255");
        measure(300, hi, np, lp);
        checks++;
        if (hi !== 300) begin
            failures++;
            $display("FAIL duty255_high: got %0d required 300", hi);
        end
    endtask

    task automatic test_coincident();
        int hi, np, lp;
        wait_ps("ps_coinc");
        repeat (253) step();
        checks++;
        if (duty_ready !== 1'b1) begin
            failures++;
            $display("FAIL coinc_ready: got %b required 1", duty_ready);
        end
        send(8'd128);
        checks++;
        if (duty_active !== 8'd128 || update_pending !== 1'b0) begin
            failures++;
            $display("FAIL coinc_load: active=%0d pend=%b required 128 0",
                     duty_active, update_pending);
        end
        step();
        checks++;
        if (period_start !== 1'b1 || update_pending !== 1'b0) begin
            failures++;
            $display("FAIL coinc_ps: ps=%b pend=%b required 1 0",
                     period_start, update_pending);
        end
        measure(255, hi, np, lp);
        checks++;
        if (hi !== 128) begin
            failures++;
            $display("FAIL duty128_high: got %0d required 128", hi);
        end
    endtask

    task automatic test_disable();
        int hi, np, lp, bad;
        repeat (10) step();
        send(8'd40);
        checks++;
        if (update_pending !== 1'b1) begin
            failures++;
            $display("FAIL pend40: got %b required 1", update_pending);
        end
        enable = 1'b0;
        step();
        checks++;
        if (duty_active !== 8'd40 || update_pending !== 1'b0
            || pwm_out !== 1'b0) begin
            failures++;
            $display("FAIL disable_apply: active=%0d pend=%b pwm=%b required 40 0 0",
                     duty_active, update_pending, pwm_out);
        end
        send(8'd30);
        checks++;
        if (duty_active !== 8'd30 || update_pending !== 1'b0
            || pwm_out !== 1'b0) begin
            failures++;
            $display("FAIL disable_load30: active=%0d pend=%b pwm=%b required 30 0 0",
                     duty_active, update_pending, pwm_out);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pwm_out !== 1'b0 || period_start !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL disabled_idle: got %0d active cycles required 0", bad);
        end
        enable = 1'b1;
        step();
        measure(255, hi, np, lp);
        checks++;
        if (hi !== 30 || np !== 1 || lp !== 0) begin
            failures++;
            $display("FAIL reenable30: high=%0d pulses=%0d at=%0d required 30 1 0",
                     hi, np, lp);
        end
    endtask

    task automatic test_reset_mid();
        repeat (74) step();
        send(8'd99);
        checks++;
        if (update_pending !== 1'b1) begin
            failures++;
            $display("FAIL pend99: got %b required 1", update_pending);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({pwm_out, period_start, duty_active, update_pending,
             duty_ready, wdog_fault} !== 13'b0_0_00000000_0_1_0) begin
            failures++;
            $display("FAIL reset_mid: got %b%b %h %b%b%b required 00 00 010",
                     pwm_out, period_start, duty_active, update_pending,
                     duty_ready, wdog_fault);
        end
        rst = 1'b0;
        step();
        checks++;
        if (period_start !== 1'b1 || pwm_out !== 1'b0) begin
            failures++;
            $display("FAIL restart: ps=%b pwm=%b required 1 0",
                     period_start, pwm_out);
        end
    endtask

    task automatic test_prescale();
        int hi, np;
        din2 = 8'd100; dv2 = 1'b1;
        step();
        dv2 = 1'b0;
        en2 = 1'b1;
        step();
        checks++;
        if (ps2 !== 1'b0) begin
            failures++;
            $display("FAIL p2_no_early_ps: got %b required 0", ps2);
        end
        step();
        hi = 0; np = 0;
        for (int i = 0; i < 510; i++) begin
            if (pwm2) hi++;
            if (ps2) np++;
            step();
        end
        checks++;
        if (hi !== 200 || np !== 1 || ps2 !== 1'b1) begin
            failures++;
            $display("FAIL p2_period: high=%0d pulses=%0d next_ps=%b required 200 1 1",
                     hi, np, ps2);
        end
        checks++;
        if (fault2 !== 1'b0) begin
            failures++;
            $display("FAIL p2_fault: got %b required 0", fault2);
        end
    endtask

`ifdef PID_PWM_WDOG_EN
    task automatic test_wdog();
        int bad, hi;
        rst = 1'b1; en2 = 1'b0;
        step();
        rst = 1'b0;
        din2 = 8'd100; dv2 = 1'b1;
        step();
        dv2 = 1'b0;
        en2 = 1'b1;
        step();
        bad = 0;
        for (int k = 0; k < 2039; k++) begin
            if (fault2 !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL wdog_early: got %0d cycles required 0", bad);
        end
        checks++;
        if (fault2 !== 1'b1 || act2 !== 8'd0 || pwm2 !== 1'b0
            || pend2 !== 1'b0) begin
            failures++;
            $display("FAIL wdog_trip: fault=%b active=%0d pwm=%b pend=%b required 1 0 0 0",
                     fault2, act2, pwm2, pend2);
        end
        din2 = 8'd90; dv2 = 1'b1;
        step();
        dv2 = 1'b0;
        hi = 0;
        for (int i = 0; i < 510; i++) begin
            if (pwm2) hi++;
            step();
        end
        checks++;
        if (fault2 !== 1'b1 || act2 !== 8'd0 || hi !== 0) begin
            failures++;
            $display("FAIL wdog_sticky: fault=%b active=%0d high=%0d required 1 0 0",
                     fault2, act2, hi);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (fault2 !== 1'b0) begin
            failures++;
            $display("FAIL wdog_clear: got %b required 0", fault2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_duty();
        test_midperiod();
        test_extremes();
        test_coincident();
        test_disable();
        test_reset_mid();
        test_prescale();
`ifdef PID_PWM_WDOG_EN
        test_wdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
